fifo_ring: RTL and testbench

Parametrised synchronous FIFO and successor to the shift-register FIFO. Uses a circular buffer with separate read/write pointers, so a push does not shift the whole array. Supports non-power-of-two depth and exposes an occupancy count plus almost-full/almost-empty flags. Sits between a producer and a consumer in one clock domain, using req/ack handshakes on both sides.

---
 rtl/fifo_ring_pkg.sv | 29 ++
 rtl/fifo_wrap_ptr.sv | 32 +++
 rtl/fifo_ring.sv | 138 +++++++++++++
 tb/tb_fifo_ring.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ring_pkg.sv
// Shared helpers for the ring-buffer FIFO: pointer reset value, a ceil-log2
// used to validate the pointer width, and the occupancy counter width rule.
package fifo_pkg;

    typedef int unsigned fifo_uint_t;

    // Value both ring pointers return to on reset.
    localparam fifo_uint_t FIFO_PTR_RESET = 0;

    // Ceil(log2(value)); a value of 0 or 1 needs 0 address bits.
    function automatic fifo_uint_t clog2(input fifo_uint_t value);
        fifo_uint_t result;
        fifo_uint_t v;
        result = 0;
        v      = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // The occupancy counter needs one bit more than a pointer so that
    // count == DEPTH is representable even when DEPTH == 2**L2D.
    function automatic fifo_uint_t count_width(input fifo_uint_t l2d);
        return l2d + 1;
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer for the ring buffer. Wraps explicitly at DEPTH-1 so
// the ring works for depths that are not a power of two.
module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int L2D   = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           inc,
    output logic [L2D-1:0] ptr
);

    localparam logic [L2D-1:0] C_LAST  = L2D'(DEPTH - 1);
    localparam logic [L2D-1:0] C_RESET = L2D'(FIFO_PTR_RESET);
    localparam logic [L2D-1:0] C_ONE   = L2D'(1);

    logic [L2D-1:0] r_ptr;

    // Advance by one per increment, folding DEPTH-1 back to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= C_RESET;
        end else if (inc) begin
            r_ptr <= (r_ptr == C_LAST) ? '0 : r_ptr + C_ONE;
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/fifo_ring.sv
// Synchronous ring-buffer FIFO with req/ack handshakes, occupancy count and
// almost-full / almost-empty flags. Non-power-of-two depths are supported.
// Optional macro FIFO_RING_FWFT_EN selects first-word fall-through output
// (data_out shows the head entry combinationally); otherwise data_out is a
// register loaded on each accepted pop (one-cycle read latency).
module fifo_ring
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int L2D      = 4,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             push_req,
    output logic             push_ack,
    input  logic             pop_req,
    output logic             pop_ack,
    output logic [WIDTH-1:0] data_out,
    output logic [L2D:0]     count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty
);

    localparam int CW = int'(count_width(L2D));

    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);
    localparam logic [CW-1:0] C_ONE   = CW'(1);

    // Parameter legality is enforced while elaborating.
    if (DEPTH < 2) begin : g_bad_depth
        $error("fifo_ring: DEPTH must be at least 2");
    end
    if (L2D < 1 || clog2(DEPTH) > L2D) begin : g_bad_l2d
        $error("fifo_ring: L2D too small for DEPTH");
    end
    if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
        $error("fifo_ring: need AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [L2D-1:0]   w_wr_ptr;
    logic [L2D-1:0]   w_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic             w_push_hsk;
    logic             w_pop_hsk;

    // Flags are pure decodes of the registered occupancy.
    always_comb begin
        w_full       = (r_count == C_DEPTH);
        w_empty      = (r_count == '0);
        almost_full  = (r_count >= C_AF);
        almost_empty = (r_count <= C_AE);
    end

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // push that coincides with an accepted pop.
    always_comb begin
        w_pop_hsk  = pop_req && !w_empty;
        w_push_hsk = push_req && (!w_full || w_pop_hsk);
    end

    assign push_ack = w_push_hsk;
    assign pop_ack  = w_pop_hsk;
    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;

    fifo_wrap_ptr #(
        .DEPTH (DEPTH),
        .L2D   (L2D)
    ) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (w_push_hsk),
        .ptr   (w_wr_ptr)
    );

    fifo_wrap_ptr #(
        .DEPTH (DEPTH),
        .L2D   (L2D)
    ) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (w_pop_hsk),
        .ptr   (w_rd_ptr)
    );

    // Storage is never reset; a push in a reset cycle is discarded.
    always_ff @(posedge clk) begin
        if (w_push_hsk && !reset) begin
            r_mem[w_wr_ptr] <= data_in;
        end
    end

    // Occupancy tracks accepted pushes minus accepted pops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case ({w_push_hsk, w_pop_hsk})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef FIFO_RING_FWFT_EN
    // Head entry falls through to the output; zero when nothing is stored.
    always_comb begin
        data_out = w_empty ? '0 : r_mem[w_rd_ptr];
    end
`else
    logic [WIDTH-1:0] r_data_out;

    // Load the head entry on each accepted pop; hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out <= '0;
        end else if (w_pop_hsk) begin
            r_data_out <= r_mem[w_rd_ptr];
        end
    end

    assign data_out = r_data_out;
`endif

endmodule

// File: tb/tb_fifo_ring.sv
// Scoreboard bench for fifo_ring: a DEPTH=16 instance for the main scenarios
// and a DEPTH=5 instance for non-power-of-two wrap-around.
module tb_fifo_ring;

    logic       clk = 1'b0;
    logic       reset;

    logic [7:0] din;
    logic       push_req, pop_req, push_ack, pop_ack;
    logic [7:0] dout;
    logic [4:0] cnt;
    logic       full, empty, af, ae;

    logic [7:0] din5;
    logic       push_req5, pop_req5, push_ack5, pop_ack5;
    logic [7:0] dout5;
    logic [3:0] cnt5;
    logic       full5, empty5, af5, ae5;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] q16[$];
    int         m16_cnt;
    logic [7:0] m16_last;
    logic [7:0] q5[$];
    int         m5_cnt;
    logic [7:0] m5_last;

    always #5 clk = ~clk;

    fifo_ring #(.WIDTH(8), .DEPTH(16), .L2D(4), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
        .clk(clk), .reset(reset), .data_in(din), .push_req(push_req), .push_ack(push_ack),
        .pop_req(pop_req), .pop_ack(pop_ack), .data_out(dout), .count(cnt),
        .full(full), .empty(empty), .almost_full(af), .almost_empty(ae));

    fifo_ring #(.WIDTH(8), .DEPTH(5), .L2D(3), .AF_LEVEL(4), .AE_LEVEL(1)) dut5 (
        .clk(clk), .reset(reset), .data_in(din5), .push_req(push_req5), .push_ack(push_ack5),
        .pop_req(pop_req5), .pop_ack(pop_ack5), .data_out(dout5), .count(cnt5),
        .full(full5), .empty(empty5), .almost_full(af5), .almost_empty(ae5));

    // One cycle on the DEPTH=16 instance; called at a falling edge.
    task automatic cycle16(input bit push, input logic [7:0] d, input bit pop);
        bit ep, eq;
        logic [7:0] exp_d;
        logic [3:0] exp_f;
        push_req = push; din = d; pop_req = pop;
        #1;
        eq = pop && (m16_cnt != 0);
        ep = push && ((m16_cnt != 16) || eq);
        n_total++;
        if (push_ack !== ep) $display("FAIL push_ack16 cnt=%0d got %b want %b", m16_cnt, push_ack, ep);
        else n_pass++;
        n_total++;
        if (pop_ack !== eq) $display("FAIL pop_ack16 cnt=%0d got %b want %b", m16_cnt, pop_ack, eq);
        else n_pass++;
`ifdef FIFO_RING_FWFT_EN
        exp_d = (m16_cnt != 0) ? q16[0] : 8'h00;
        n_total++;
        if (dout !== exp_d) $display("FAIL dout16_fwft got %h want %h", dout, exp_d);
        else n_pass++;
`endif
        if (ep) q16.push_back(d);
        if (eq) m16_last = q16.pop_front();
        m16_cnt = m16_cnt + int'(ep) - int'(eq);
        @(posedge clk); #1;
`ifndef FIFO_RING_FWFT_EN
        exp_d = m16_last;
        n_total++;
        if (dout !== exp_d) $display("FAIL dout16 got %h want %h", dout, exp_d);
        else n_pass++;
`endif
        n_total++;
        if (cnt !== 5'(m16_cnt)) $display("FAIL count16 got %0d want %0d", cnt, m16_cnt);
        else n_pass++;
        exp_f = {m16_cnt == 16, m16_cnt == 0, m16_cnt >= 14, m16_cnt <= 2};
        n_total++;
        if ({full, empty, af, ae} !== exp_f)
            $display("FAIL flags16 cnt=%0d got %b want %b", m16_cnt, {full, empty, af, ae}, exp_f);
        else n_pass++;
        @(negedge clk);
        push_req = 1'b0; pop_req = 1'b0;
    endtask

    // One cycle on the DEPTH=5 instance; called at a falling edge.
    task automatic cycle5(input bit push, input logic [7:0] d, input bit pop);
        bit ep, eq;
        logic [7:0] exp_d;
        logic [3:0] exp_f;
        push_req5 = push; din5 = d; pop_req5 = pop;
        #1;
        eq = pop && (m5_cnt != 0);
        ep = push && ((m5_cnt != 5) || eq);
        n_total++;
        if ({push_ack5, pop_ack5} !== {ep, eq})
            $display("FAIL acks5 cnt=%0d got %b want %b", m5_cnt, {push_ack5, pop_ack5}, {ep, eq});
        else n_pass++;
`ifdef FIFO_RING_FWFT_EN
        exp_d = (m5_cnt != 0) ? q5[0] : 8'h00;
        n_total++;
        if (dout5 !== exp_d) $display("FAIL dout5_fwft got %h want %h", dout5, exp_d);
        else n_pass++;
`endif
        if (ep) q5.push_back(d);
        if (eq) m5_last = q5.pop_front();
        m5_cnt = m5_cnt + int'(ep) - int'(eq);
        @(posedge clk); #1;
`ifndef FIFO_RING_FWFT_EN
        exp_d = m5_last;
        n_total++;
        if (dout5 !== exp_d) $display("FAIL dout5 got %h want %h", dout5, exp_d);
        else n_pass++;
`endif
        n_total++;
        if (cnt5 !== 4'(m5_cnt)) $display("FAIL count5 got %0d want %0d", cnt5, m5_cnt);
        else n_pass++;
        exp_f = {m5_cnt == 5, m5_cnt == 0, m5_cnt >= 4, m5_cnt <= 1};
        n_total++;
        if ({full5, empty5, af5, ae5} !== exp_f)
            $display("FAIL flags5 cnt=%0d got %b want %b", m5_cnt, {full5, empty5, af5, ae5}, exp_f);
        else n_pass++;
        @(negedge clk);
        push_req5 = 1'b0; pop_req5 = 1'b0;
    endtask

    // One reset cycle, optionally with a push request held high.
    task automatic do_reset(input bit push_during);
        reset = 1'b1; push_req = push_during; din = 8'h5A; pop_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; push_req = 1'b0;
        q16.delete(); m16_cnt = 0; m16_last = 8'h00;
        q5.delete();  m5_cnt = 0;  m5_last = 8'h00;
        n_total++;
        if (cnt !== 5'd0) $display("FAIL reset_count got %0d want 0", cnt);
        else n_pass++;
        n_total++;
        if ({full, empty, af, ae} !== 4'b0101)
            $display("FAIL reset_flags got %b want 0101", {full, empty, af, ae});
        else n_pass++;
        n_total++;
        if (dout !== 8'h00) $display("FAIL reset_dout got %h want 00", dout);
        else n_pass++;
        n_total++;
        if (cnt5 !== 4'd0 || empty5 !== 1'b1)
            $display("FAIL reset_dut5 count=%0d empty=%b want 0/1", cnt5, empty5);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset(1'b0);
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) cycle16(1'b1, 8'(i), 1'b0);
        // Seventeenth push must be refused.
        push_req = 1'b1; din = 8'h11;
        #1;
        n_total++;
        if (push_ack !== 1'b0) $display("FAIL push_when_full got %b want 0", push_ack);
        else n_pass++;
        cycle16(1'b1, 8'h11, 1'b0);
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) cycle16(1'b0, 8'h00, 1'b1);
        cycle16(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 16; i++) cycle16(1'b1, 8'(8'h20 + i), 1'b0);
        push_req = 1'b1; pop_req = 1'b1; din = 8'hAA;
        #1;
        n_total++;
        if ({push_ack, pop_ack} !== 2'b11) $display("FAIL full_simul_acks got %b want 11", {push_ack, pop_ack});
        else n_pass++;
        cycle16(1'b1, 8'hAA, 1'b1);
        for (int i = 0; i < 16; i++) cycle16(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_empty_edge();
        cycle16(1'b1, 8'h77, 1'b1);
        cycle16(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) cycle16(1'b1, 8'(8'h40 + i), 1'b0);
        do_reset(1'b1);
        cycle16(1'b1, 8'h99, 1'b0);
        cycle16(1'b0, 8'h00, 1'b1);
        cycle16(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++)
            cycle16(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        while (m16_cnt != 0) cycle16(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20; i++)
            cycle5((i % 4) != 3, 8'(8'hC0 + i), (i % 3) != 0);
        for (int i = 0; i < 6; i++) cycle5(1'b1, 8'(8'hE0 + i), 1'b0);
        for (int i = 0; i < 6; i++) cycle5(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        reset = 1'b0;
        din = 8'h00; push_req = 1'b0; pop_req = 1'b0;
        din5 = 8'h00; push_req5 = 1'b0; pop_req5 = 1'b0;
        m16_cnt = 0; m16_last = 8'h00; m5_cnt = 0; m5_last = 8'h00;
        @(negedge clk);
        test_reset();
        test_fill();
        test_drain();
        test_full_simul();
        test_empty_edge();
        test_reset_mid();
        test_back_to_back();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
